// File: rtl/cg_pkg.sv
// cg_pkg: shared types and helpers for the clock-gate enable generator.
//   cg_state_e : sleep/wake/active FSM encoding (3 is illegal)
//   cnt_width  : bit width needed to count 0..n-1 (minimum 1)
package cg_pkg;

  typedef enum logic [1:0] {
    CG_SLEEP  = 2'd0,
    CG_WAKE   = 2'd1,
    CG_ACTIVE = 2'd2
  } cg_state_e;

  // Width of a down/up counter holding values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/cg_idle_timer.sv
// cg_idle_timer: counts idle cycles while the enable generator is active.
//   CLK, RST : clock, asynchronous active-high reset
//   clear    : return count to zero (has priority over inc)
//   inc      : advance count by one
//   expired  : count has reached IDLE_CYCLES-1
module cg_idle_timer
  import cg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = cnt_width(IDLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count; the owner clears on expiry, so no wrap handling is needed.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/cg_enable_gen.sv
// cg_enable_gen: drives D_IN/EN and the clock-gate enable of a gated data
// register. Redundant writes (data equal to the last written value) are
// consumed without pulsing EN; the gate closes after IDLE_CYCLES idle cycles
// and reopens through a WAKE_CYCLES warm-up when the source has data.
//   CLK, RST   : clock, asynchronous active-high reset
//   SRC_VALID  : source holds a word
//   SRC_DATA   : source word
//   SRC_READY  : word accepted this cycle (registered, high only in ACTIVE)
//   D_IN, EN   : registered data / one-cycle write enable to the register
//   CG_EN      : registered clock-gate enable (decode of next state)
//   STATE      : FSM state for debug
module cg_enable_gen
  import cg_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SRC_VALID,
  input  logic [WIDTH-1:0] SRC_DATA,
  output logic             SRC_READY,
  output logic [WIDTH-1:0] D_IN,
  output logic             EN,
  output logic             CG_EN,
  output logic [1:0]       STATE
);

  localparam int unsigned WCW = cnt_width(WAKE_CYCLES);
  localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES - 32'd1);

  cg_state_e        state_q;
  cg_state_e        state_d;
  logic [WCW-1:0]   wake_q;
  logic [WCW-1:0]   wake_d;
  logic             ready_q;
  logic             cg_en_q;
  logic             en_q;
  logic [WIDTH-1:0] d_in_q;
  logic [WIDTH-1:0] shadow_q;
  logic             shadow_vld_q;

  logic xfer_c;
  logic eff_c;
  logic idle_clear;
  logic idle_inc;
  logic idle_expired;

  // A transfer only writes when the shadow is empty or the data differs.
  assign xfer_c = SRC_VALID & ready_q;
  assign eff_c  = xfer_c & (~shadow_vld_q | (SRC_DATA != shadow_q));

  cg_idle_timer #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_idle_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (idle_clear),
    .inc    (idle_inc),
    .expired(idle_expired)
  );

  // Next-state and counter control.
  always_comb begin
    state_d    = state_q;
    wake_d     = wake_q;
    idle_clear = 1'b0;
    idle_inc   = 1'b0;
    case (state_q)
      CG_SLEEP: begin
        idle_clear = 1'b1;
        if (SRC_VALID) begin
          state_d = CG_WAKE;
          wake_d  = WAKE_LOAD;
        end
      end
      CG_WAKE: begin
        // Committed once started: SRC_VALID dropping does not abort.
        idle_clear = 1'b1;
        if (wake_q == '0) begin
          state_d = CG_ACTIVE;
        end else begin
          wake_d = wake_q - WCW'(1);
        end
      end
      CG_ACTIVE: begin
        // Suppressed transfers count as idle cycles.
        if (eff_c) begin
          idle_clear = 1'b1;
        end else if (idle_expired) begin
          idle_clear = 1'b1;
          state_d    = CG_SLEEP;
        end else begin
          idle_inc = 1'b1;
        end
      end
      default: begin
        idle_clear = 1'b1;
        wake_d     = '0;
        state_d    = CG_SLEEP;
      end
    endcase
  end

  // State, handshake and gate-enable registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CG_SLEEP;
      wake_q  <= '0;
      ready_q <= 1'b0;
      cg_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      ready_q <= (state_d == CG_ACTIVE);
      cg_en_q <= (state_d != CG_SLEEP);
    end
  end

  // Write path and shadow copy of the last written value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_q         <= 1'b0;
      d_in_q       <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      en_q <= eff_c;
      if (eff_c) begin
        d_in_q       <= SRC_DATA;
        shadow_q     <= SRC_DATA;
        shadow_vld_q <= 1'b1;
      end
    end
  end

  assign SRC_READY = ready_q;
  assign D_IN      = d_in_q;
  assign EN        = en_q;
  assign CG_EN     = cg_en_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_cg_enable_gen.sv
// tb_cg_enable_gen: directed bench for cg_enable_gen with a write scoreboard.
module tb_cg_enable_gen;

  logic       CLK;
  logic       RST;
  logic       SRC_VALID;
  logic [7:0] SRC_DATA;
  logic       SRC_READY;
  logic [7:0] D_IN;
  logic       EN;
  logic       CG_EN;
  logic [1:0] STATE;

  int total;
  int bad;
  int en_seen;

  logic [7:0] exp_q[$];
  logic [7:0] m_shadow;
  bit         m_vld;

  cg_enable_gen #(
    .WIDTH      (8),
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SRC_VALID(SRC_VALID),
    .SRC_DATA (SRC_DATA),
    .SRC_READY(SRC_READY),
    .D_IN     (D_IN),
    .EN       (EN),
    .CG_EN    (CG_EN),
    .STATE    (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a word and hold it until accepted; model decides if EN must pulse.
  // Called and returns just after a rising edge.
  task automatic send(input logic [7:0] d);
    bit done;
    done = 1'b0;
    SRC_VALID = 1'b1;
    SRC_DATA  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (SRC_READY === 1'b1) begin
        if (!m_vld || d != m_shadow) begin
          exp_q.push_back(d);
          m_shadow = d;
          m_vld    = 1'b1;
        end
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  // Every EN pulse must match the oldest expected write.
  always @(negedge CLK) begin
    logic [7:0] e;
    if (EN === 1'b1) begin
      en_seen++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL en_spurious observed_d_in=%0d expected=no_write", D_IN);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert (D_IN === e) else begin
          bad++;
          $error("FAIL en_d_in observed=%0d expected=%0d", D_IN, e);
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; en_seen = 0;
    m_shadow = 8'd0; m_vld = 1'b0;
    RST = 1'b1; SRC_VALID = 1'b0; SRC_DATA = 8'd0;

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_d_in",  32'(D_IN), 32'd0);
    chk("rst_en",    32'(EN), 32'd0);
    chk("rst_cg_en", 32'(CG_EN), 32'd0);
    chk("rst_ready", 32'(SRC_READY), 32'd0);
    chk("rst_state", 32'(STATE), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Wake path timing
    @(posedge CLK); #1;
    SRC_VALID = 1'b1; SRC_DATA = 8'd1;
    @(negedge CLK);
    chk("pre_wake_state", 32'(STATE), 32'd0);
    @(negedge CLK);                       // after edge e
    chk("wake_cg_en", 32'(CG_EN), 32'd1);
    chk("wake_state", 32'(STATE), 32'd1);
    chk("wake_ready0", 32'(SRC_READY), 32'd0);
    @(negedge CLK);                       // after e+1
    chk("wake_ready1", 32'(SRC_READY), 32'd0);
    @(negedge CLK);                       // after e+2
    chk("wake_ready2", 32'(SRC_READY), 32'd1);
    chk("active_state", 32'(STATE), 32'd2);
    exp_q.push_back(8'd1); m_shadow = 8'd1; m_vld = 1'b1;
    @(posedge CLK); #1;                   // transfer at e+3
    SRC_VALID = 1'b0;
    @(negedge CLK);
    chk("first_en", 32'(EN), 32'd1);
    chk("first_d_in", 32'(D_IN), 32'd1);
    @(negedge CLK);
    chk("first_en_single", 32'(EN), 32'd0);
    chk("first_d_in_hold", 32'(D_IN), 32'd1);
    @(posedge CLK); #1;

    // Suppression: one pulse for three equal words
    send(8'd13); send(8'd13); send(8'd13);
    SRC_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("supp_d_in", 32'(D_IN), 32'd13);
    chk("supp_en_low", 32'(EN), 32'd0);
    chk("supp_en_count", 32'(en_seen), 32'd2);
    @(posedge CLK); #1;

    // Streaming, then idle sleep IDLE_CYCLES edges after last write
    send(8'd3); send(8'd13); send(8'd254);
    SRC_VALID = 1'b0;
    repeat (4) @(negedge CLK);            // after k+3
    chk("stream_en_count", 32'(en_seen), 32'd5);
    chk("idle_k3_state", 32'(STATE), 32'd2);
    @(negedge CLK);                       // after k+4
    chk("idle_sleep_state", 32'(STATE), 32'd0);
    chk("idle_sleep_cg_en", 32'(CG_EN), 32'd0);
    chk("idle_sleep_ready", 32'(SRC_READY), 32'd0);
    @(posedge CLK); #1;

    // Suppressed write counts as idle
    send(8'd0); send(8'd0);
    SRC_VALID = 1'b0;
    repeat (3) @(negedge CLK);            // after k+3
    chk("supp_idle_k3_state", 32'(STATE), 32'd2);
    @(negedge CLK);                       // after k+4
    chk("supp_idle_sleep", 32'(STATE), 32'd0);
    chk("supp_idle_cg_en", 32'(CG_EN), 32'd0);
    chk("supp_idle_d_in", 32'(D_IN), 32'd0);
    @(posedge CLK); #1;

    // Reset during WAKE
    SRC_VALID = 1'b1; SRC_DATA = 8'd0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rw_state_wake", 32'(STATE), 32'd1);
    RST = 1'b1;
    #1;
    chk("rw_state", 32'(STATE), 32'd0);
    chk("rw_cg_en", 32'(CG_EN), 32'd0);
    chk("rw_ready", 32'(SRC_READY), 32'd0);
    m_vld = 1'b0; m_shadow = 8'd0;
    @(posedge CLK); #1;
    RST = 1'b0;
    send(8'd0);
    SRC_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rw_en_after", 32'(en_seen), 32'd7);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
